counter_ctrl: RTL and testbench

- Sequences the lab up/down `counter` datapath.
- Arbitrates between two requesters for the counter's control inputs:
  - debounced/edge-detected board buttons;
  - a host command port (valid/ready).
- Adds an auto-count mode that steps the counter once per CYCLES_PER_SECOND cycles.
- Sits between the button conditioner / host interface and the counter; issues at most one single-cycle counter action per cycle.

---
 rtl/counter_ctrl_pkg.sv | 43 ++++
 rtl/counter_ctrl_if.sv | 21 ++
 rtl/counter_ctrl_tick_gen.sv | 32 +++
 rtl/counter_ctrl.sv | 132 +++++++++++++
 tb/tb_counter_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller slice.
package counter_ctrl_pkg;

    // Current counting mode as seen on the mode output.
    typedef enum logic [1:0] {
        MANUAL       = 2'b00,
        AUTO_UP      = 2'b01,
        AUTO_DOWN    = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_t;

    // Host command op codes carried on cmd_op.
    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_CLR  = 2'b10,
        OP_MODE = 2'b11
    } op_t;

    // Single counter action chosen per cycle by the arbiter.
    typedef enum logic [1:0] {
        ACT_NONE = 2'b00,
        ACT_INC  = 2'b01,
        ACT_DEC  = 2'b10,
        ACT_CLR  = 2'b11
    } act_t;

    // Bit positions inside btn_pulse.
    localparam int unsigned BTN_CLR  = 3;
    localparam int unsigned BTN_INC  = 2;
    localparam int unsigned BTN_DEC  = 1;
    localparam int unsigned BTN_MODE = 0;

    // One step around MANUAL -> AUTO_UP -> AUTO_DOWN -> MANUAL.
    function automatic mode_t mode_advance(input mode_t m);
        case (m)
            MANUAL:    return AUTO_UP;
            AUTO_UP:   return AUTO_DOWN;
            default:   return MANUAL;
        endcase
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Host command port: valid/ready handshake carrying a 2-bit op.
interface counter_ctrl_if;

    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    // Host side drives the command, controller answers with ready.
    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );

endinterface

// File: rtl/counter_ctrl_tick_gen.sv
// Auto-mode divider: pulses tick once every CYCLES_PER_SECOND enabled cycles.
module tick_gen #(
    parameter int unsigned CYCLES_PER_SECOND = 125_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned CW_RAW = $clog2(CYCLES_PER_SECOND + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_SECOND - 1);

    logic [CW-1:0] count;

    // Tick is taken straight from the count so it lines up with the cycle it belongs to.
    assign tick = en & (count == LAST);

    // Divider count: restart on sync_clr, wrap after the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (sync_clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Counter sequencer: arbitrates buttons, host commands and auto ticks into
// one registered inc/dec/clr strobe per cycle, and owns the mode FSM.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned CYCLES_PER_SECOND = 125_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           btn_pulse,
    counter_ctrl_if.slave        host,
    output logic                 ctr_inc,
    output logic                 ctr_dec,
    output logic                 ctr_clr,
    output logic [1:0]           mode
);

    mode_t mode_q;
    mode_t mode_d;
    logic  tick_pending_q;
    logic  tick_pending_d;
    act_t  act;

    logic btn_action;
    logic cmd_accept;
    logic host_inc;
    logic host_dec;
    logic host_clr;
    logic host_mode;
    logic clear_act;
    logic mode_change;
    logic auto_mode;
    logic tick;
    logic tick_avail;
    logic tick_blocked;
    logic div_clr;

    // The host only ever gets the slot when no button asks for an action.
    assign btn_action      = btn_pulse[BTN_CLR] | btn_pulse[BTN_INC] | btn_pulse[BTN_DEC];
    assign host.cmd_ready  = ~btn_action;
    assign cmd_accept      = host.cmd_valid & ~btn_action;

    assign host_inc  = cmd_accept & (host.cmd_op == OP_INC);
    assign host_dec  = cmd_accept & (host.cmd_op == OP_DEC);
    assign host_clr  = cmd_accept & (host.cmd_op == OP_CLR);
    assign host_mode = cmd_accept & (host.cmd_op == OP_MODE);

    assign clear_act   = btn_pulse[BTN_CLR] | host_clr;
    assign mode_change = (mode_q == MODE_ILLEGAL) | btn_pulse[BTN_MODE] | host_mode;
    assign auto_mode   = (mode_q == AUTO_UP) | (mode_q == AUTO_DOWN);
    assign tick_avail  = auto_mode & (tick | tick_pending_q);
    assign div_clr     = mode_change | clear_act | (mode_q == MANUAL);

    tick_gen #(
        .CYCLES_PER_SECOND (CYCLES_PER_SECOND)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (auto_mode),
        .sync_clr (div_clr),
        .tick     (tick)
    );

    // Pick the single counter action for this cycle, highest priority first.
    always_comb begin
        act          = ACT_NONE;
        tick_blocked = 1'b0;
        if (clear_act) begin
            act = ACT_CLR;
        end else if (btn_pulse[BTN_INC] | btn_pulse[BTN_DEC]) begin
            // inc+dec together cancel but still occupy the slot
            tick_blocked = tick_avail;
            if (btn_pulse[BTN_INC] & ~btn_pulse[BTN_DEC]) begin
                act = ACT_INC;
            end else if (btn_pulse[BTN_DEC] & ~btn_pulse[BTN_INC]) begin
                act = ACT_DEC;
            end
        end else if (host_inc | host_dec) begin
            tick_blocked = tick_avail;
            act          = host_inc ? ACT_INC : ACT_DEC;
        end else if (tick_avail) begin
            act = (mode_q == AUTO_UP) ? ACT_INC : ACT_DEC;
        end
    end

    // Next mode: button and host toggles may both land, advancing twice.
    always_comb begin
        mode_d = mode_q;
        if (mode_q == MODE_ILLEGAL) begin
            mode_d = MANUAL;
        end else begin
            if (btn_pulse[BTN_MODE]) begin
                mode_d = mode_advance(mode_d);
            end
            if (host_mode) begin
                mode_d = mode_advance(mode_d);
            end
        end
    end

    // A pending tick survives only while blocked; issuing, clears and mode changes drop it.
    always_comb begin
        tick_pending_d = tick_blocked & ~(clear_act | mode_change);
    end

    // Mode and pending-tick state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q         <= MANUAL;
            tick_pending_q <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            tick_pending_q <= tick_pending_d;
        end
    end

    // Registered one-hot strobes to the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_inc <= 1'b0;
            ctr_dec <= 1'b0;
            ctr_clr <= 1'b0;
        end else begin
            ctr_inc <= (act == ACT_INC);
            ctr_dec <= (act == ACT_DEC);
            ctr_clr <= (act == ACT_CLR);
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: two instances (period 4 and period 1)
// share one stimulus stream and are checked against a cycle-level model.
`timescale 1ns/1ps
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       cmd_valid;
    logic [1:0] cmd_op;

    logic       inc0, dec0, clr0, inc1, dec1, clr1;
    logic [1:0] mode0, mode1;

    counter_ctrl_if hif0 ();
    counter_ctrl_if hif1 ();

    assign hif0.cmd_valid = cmd_valid;
    assign hif0.cmd_op    = cmd_op;
    assign hif1.cmd_valid = cmd_valid;
    assign hif1.cmd_op    = cmd_op;

    counter_ctrl #(.CYCLES_PER_SECOND(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_pulse(btn), .host(hif0),
        .ctr_inc(inc0), .ctr_dec(dec0), .ctr_clr(clr0), .mode(mode0)
    );

    counter_ctrl #(.CYCLES_PER_SECOND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_pulse(btn), .host(hif1),
        .ctr_inc(inc1), .ctr_dec(dec1), .ctr_clr(clr1), .mode(mode1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state, one slot per instance.
    int          np [2] = '{4, 1};
    int          m_mode [2];
    longint      m_anchor [2];
    bit          m_pend [2];
    longint      cyc = 0;
    logic [4:0]  q0 [$];
    logic [4:0]  q1 [$];

    // Host-side pending command.
    bit          hv  = 1'b0;
    logic [1:0]  hop = 2'b00;

    int cnt_inc0 = 0, cnt_dec0 = 0, cnt_inc1 = 0, cnt_dec1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit tick_due(input int i);
        return (m_mode[i] != 0) && (cyc >= m_anchor[i]) && (((cyc - m_anchor[i]) % np[i]) == 0);
    endfunction

    // One cycle of the behavioural model; returns {inc,dec,clr,mode} expected next cycle.
    task automatic model_step(input int i, input logic [3:0] b, input bit acc,
                              input logic [1:0] op, output logic [4:0] e);
        bit auto_m, avail, blocked, clear, hclr, hinc, hdec, hmode;
        int act, toggles;
        auto_m  = (m_mode[i] != 0);
        avail   = auto_m && (tick_due(i) || m_pend[i]);
        hinc    = acc && (op == 2'd0);
        hdec    = acc && (op == 2'd1);
        hclr    = acc && (op == 2'd2);
        hmode   = acc && (op == 2'd3);
        clear   = b[3] || hclr;
        blocked = 1'b0;
        act     = 0;
        if (clear) begin
            act = 3;
        end else if (b[2] || b[1]) begin
            blocked = 1'b1;
            act = (b[2] && b[1]) ? 0 : (b[2] ? 1 : 2);
        end else if (hinc || hdec) begin
            blocked = 1'b1;
            act = hinc ? 1 : 2;
        end else if (avail) begin
            act = (m_mode[i] == 1) ? 1 : 2;
        end
        toggles = int'(b[0]) + int'(hmode);
        m_pend[i] = !(clear || toggles != 0) && avail && blocked;
        if (clear || toggles != 0 || m_mode[i] == 0)
            m_anchor[i] = cyc + np[i];
        m_mode[i] = (m_mode[i] + toggles) % 3;
        e = {act == 1, act == 2, act == 3, 2'(m_mode[i])};
    endtask

    task automatic step(input logic [3:0] b);
        logic [4:0] e0, e1;
        bit rdy, acc;
        @(negedge clk);
        btn       = b;
        cmd_valid = hv;
        cmd_op    = hop;
        #1;
        rdy = !(b[3] || b[2] || b[1]);
        check("cmd_ready0", {31'd0, hif0.cmd_ready}, {31'd0, rdy});
        check("cmd_ready1", {31'd0, hif1.cmd_ready}, {31'd0, rdy});
        acc = hv && rdy;
        model_step(0, b, acc, hop, e0);
        model_step(1, b, acc, hop, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        cyc++;
        if (acc) hv = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic host_cmd(input logic [1:0] op);
        hv  = 1'b1;
        hop = op;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        hv        = 1'b0;
        cmd_valid = 1'b0;
        btn       = '0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]   = 0;
            m_pend[i]   = 1'b0;
            m_anchor[i] = 0;
        end
    endtask

    // Monitor: every cycle the DUT presents strobes and mode; compare against the queue.
    always @(posedge clk) begin
        logic [4:0] e;
        #1;
        if (rst_n) begin
            cnt_inc0 += int'(inc0);
            cnt_dec0 += int'(dec0);
            cnt_inc1 += int'(inc1);
            cnt_dec1 += int'(dec1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("dut0_out", {27'd0, inc0, dec0, clr0, mode0}, {27'd0, e});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dut1_out", {27'd0, inc1, dec1, clr1, mode1}, {27'd0, e});
            end
        end
    end

    initial begin
        logic [3:0] b;
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_strobes", {29'd0, inc0, dec0, clr0}, 32'd0);
        check("reset_mode", {30'd0, mode0}, 32'd0);
        rst_n = 1'b1;

        // idle after reset
        repeat (10) step(4'b0000);

        // manual button inc and host dec
        step(4'b0100);
        step(4'b0000);
        host_cmd(2'd1);
        step(4'b0000);
        step(4'b0000);

        // contention: button wins, host retried next cycle
        host_cmd(2'd0);
        step(4'b0100);
        step(4'b0000);
        step(4'b0000);
        step(4'b1100);
        step(4'b0110);
        step(4'b0000);

        // auto up cadence
        step(4'b0001);
        cnt_inc0 = 0; cnt_inc1 = 0;
        repeat (20) step(4'b0000);
        check("autoup_count_p4", cnt_inc0, 5);
        check("autoup_count_p1", cnt_inc1, 20);

        // tick deferral: dec button in the exact tick cycle of dut0
        for (int k = 0; k < 8 && !tick_due(0); k++) step(4'b0000);
        check("tick_found", {31'd0, tick_due(0)}, 32'd1);
        step(4'b0010);
        repeat (8) step(4'b0000);

        // auto down cadence
        step(4'b0001);
        cnt_dec0 = 0; cnt_dec1 = 0;
        repeat (12) step(4'b0000);
        check("autodown_count_p4", cnt_dec0, 3);
        check("autodown_count_p1", cnt_dec1, 12);

        // host clear in auto down restarts the divider
        repeat (2) step(4'b0000);
        host_cmd(2'd2);
        step(4'b0000);
        repeat (10) step(4'b0000);

        // back to manual: no further ticks
        step(4'b0001);
        cnt_inc0 = 0; cnt_dec0 = 0;
        repeat (10) step(4'b0000);
        check("manual_quiet", cnt_inc0 + cnt_dec0, 0);

        // double toggle (button + host mode) in one cycle
        host_cmd(2'd3);
        step(4'b0001);
        repeat (6) step(4'b0000);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            if (!hv && $urandom_range(0, 2) == 0) host_cmd(2'($urandom_range(0, 3)));
            b = '0;
            b[3] = ($urandom_range(0, 15) == 0);
            b[2] = ($urandom_range(0, 5) == 0);
            b[1] = ($urandom_range(0, 5) == 0);
            b[0] = ($urandom_range(0, 19) == 0);
            step(b);
        end

        // reset in the middle of a strobe while in an auto mode
        hv = 1'b0;
        step(4'b0000);
        while (m_mode[0] != 1) step(4'b0001);
        step(4'b0100);
        check("pre_reset_inc", {31'd0, inc0}, 32'd1);
        do_reset();
        #1;
        check("midreset_strobes0", {29'd0, inc0, dec0, clr0}, 32'd0);
        check("midreset_strobes1", {29'd0, inc1, dec1, clr1}, 32'd0);
        check("midreset_mode0", {30'd0, mode0}, 32'd0);
        check("midreset_mode1", {30'd0, mode1}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_inc0 = 0; cnt_dec0 = 0;
        repeat (10) step(4'b0000);
        check("post_reset_quiet", cnt_inc0 + cnt_dec0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
